// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared types and constants for the boot-time instruction-memory loader.
//   state_t        : loader FSM state encoding
//   BYTES_PER_WORD : bytes packed into one instruction word
//   BYTE_W         : width of one byte on the host link
// Optional feature macro: LOADER_CSUM_EN (adds the CSUM state).
// -----------------------------------------------------------------------------
package loader_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int BYTE_W         = 8;
   localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;
   localparam int CNT_W          = $clog2(BYTES_PER_WORD);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RECV  = 3'd1,
      WRITE = 3'd2,
`ifdef LOADER_CSUM_EN
      CSUM  = 3'd3,
`endif
      DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Bundles the loader control, the byte-stream handshake and the instruction
// memory write port.
//   start/len               : load command (len in words)
//   in_valid/in_data/in_ready : host byte stream
//   we/waddr/wdata          : instruction-memory write port
//   busy/core_hold/done/err : status
// Modports: slave (the loader), master (host / memory side).
// -----------------------------------------------------------------------------
interface imem_loader_if
   import loader_pkg::*;
#(
   parameter int ADDR_W = 4
);
   logic              start;
   logic [ADDR_W:0]   len;
   logic              in_valid;
   logic [BYTE_W-1:0] in_data;
   logic              in_ready;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [WORD_W-1:0] wdata;
   logic              busy;
   logic              core_hold;
   logic              done;
   logic              err;

   modport slave (
      input  start, len, in_valid, in_data,
      output in_ready, we, waddr, wdata, busy, core_hold, done, err
   );

   modport master (
      output start, len, in_valid, in_data,
      input  in_ready, we, waddr, wdata, busy, core_hold, done, err
   );

endinterface

// File: rtl/imem_loader_word_packer.sv
// -----------------------------------------------------------------------------
// word_packer
// Little-endian byte-to-word packer: the k-th accepted byte lands in
// word[8k+7:8k].
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart packing at byte 0 (word contents zeroed)
//   shift_en   : accept byte_in this cycle
//   byte_in    : incoming byte
//   word       : packed word (registered)
//   word_full  : this cycle's accepted byte completes the word
// -----------------------------------------------------------------------------
module word_packer
   import loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              shift_en,
   input  logic [BYTE_W-1:0] byte_in,
   output logic [WORD_W-1:0] word,
   output logic              word_full
);

   logic [CNT_W-1:0]  cnt_reg;
   logic [WORD_W-1:0] word_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg  <= '0;
         word_reg <= '0;
      end else if (clear) begin
         cnt_reg  <= '0;
         word_reg <= '0;
      end else if (shift_en) begin
         word_reg[cnt_reg*BYTE_W +: BYTE_W] <= byte_in;
         cnt_reg                            <= cnt_reg + 1'b1;
      end
   end

   assign word      = word_reg;
   assign word_full = shift_en && (cnt_reg == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Boot loader: receives a byte stream, packs it into 32-bit words and writes
// them to consecutive instruction-memory addresses while holding the core in
// reset. done/err are sticky until the next accepted start.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : imem_loader_if.slave (command, byte stream, write port, status)
// Macro LOADER_CSUM_EN: when defined, one trailing checksum byte (8-bit
// modular sum of all data bytes) is consumed after the last word and a
// mismatch sets err. When undefined, err is tied low.
// -----------------------------------------------------------------------------
module imem_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W = 4
)(
   input logic          clk,
   input logic          rst_n,
   imem_loader_if.slave bus
);

   localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

   state_t            state_reg, state_next;
   logic [ADDR_W:0]   len_reg;
   logic [ADDR_W-1:0] idx_reg;
   logic [ADDR_W:0]   len_clamped;
   logic              accept_start;
   logic              in_ready_int;
   logic              in_csum;
   logic              byte_fire;
   logic              shift_en;
   logic              pack_clear;
   logic              word_full;
   logic              last_word;
   logic              err_reg;
   logic [WORD_W-1:0] word;

   assign len_clamped  = (bus.len > MAX_LEN) ? MAX_LEN : bus.len;
   // start is only honoured while not loading
   assign accept_start = bus.start && ((state_reg == IDLE) || (state_reg == DONE));
   assign in_ready_int = (state_reg == RECV) || in_csum;
   assign byte_fire    = bus.in_valid && in_ready_int;
   assign shift_en     = byte_fire && (state_reg == RECV);
   assign pack_clear   = accept_start || (state_reg == WRITE);
   assign last_word    = ({1'b0, idx_reg} == (len_reg - 1'b1));

   word_packer u_packer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (pack_clear),
      .shift_en  (shift_en),
      .byte_in   (bus.in_data),
      .word      (word),
      .word_full (word_full)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE, DONE: begin
            if (bus.start) state_next = (len_clamped == '0) ? DONE : RECV;
         end
         RECV: begin
            if (word_full) state_next = WRITE;
         end
         WRITE: begin
            if (last_word) begin
`ifdef LOADER_CSUM_EN
               state_next = CSUM;
`else
               state_next = DONE;
`endif
            end else begin
               state_next = RECV;
            end
         end
`ifdef LOADER_CSUM_EN
         CSUM: begin
            if (byte_fire) state_next = DONE;
         end
`endif
         default: state_next = IDLE;
      endcase
   end

   // Word index only advances between words, so waddr stays below len.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_reg <= '0;
         idx_reg <= '0;
      end else if (accept_start) begin
         len_reg <= len_clamped;
         idx_reg <= '0;
      end else if ((state_reg == WRITE) && !last_word) begin
         idx_reg <= idx_reg + 1'b1;
      end
   end

`ifdef LOADER_CSUM_EN
   logic [BYTE_W-1:0] sum_reg;

   assign in_csum = (state_reg == CSUM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_reg <= '0;
         err_reg <= 1'b0;
      end else if (accept_start) begin
         sum_reg <= '0;
         err_reg <= 1'b0;
      end else begin
         if (shift_en)
            sum_reg <= sum_reg + bus.in_data;
         if (in_csum && byte_fire)
            err_reg <= (bus.in_data != sum_reg);
      end
   end
`else
   assign in_csum = 1'b0;
   assign err_reg = 1'b0;
`endif

   // All outputs decode registered state/datapath values only.
   assign bus.in_ready  = in_ready_int;
   assign bus.we        = (state_reg == WRITE);
   assign bus.waddr     = idx_reg;
   assign bus.wdata     = word;
   assign bus.busy      = (state_reg == RECV) || (state_reg == WRITE) || in_csum;
   assign bus.core_hold = bus.busy;
   assign bus.done      = (state_reg == DONE);
   assign bus.err       = err_reg;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Directed bench for imem_loader. Inputs change 1 time unit after the rising
// edge; outputs and handshakes are observed on the falling edge.
// Honours LOADER_CSUM_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_imem_loader;
   import loader_pkg::*;

   localparam int ADDR_W = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

   imem_loader #(.ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   // write / byte monitor
   int          wr_cnt   = 0;
   int          byte_cnt = 0;
   logic [31:0] wr_addr [0:31];
   logic [31:0] wr_data [0:31];

   always @(negedge clk) begin
      if (bus.we) begin
         $display("[TB] write addr=%0d data=0x%08h", bus.waddr, bus.wdata);
         if (wr_cnt < 32) begin
            wr_addr[wr_cnt] = 32'(bus.waddr);
            wr_data[wr_cnt] = bus.wdata;
         end
         wr_cnt = wr_cnt + 1;
      end
      if (bus.in_valid && bus.in_ready) byte_cnt = byte_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run = tests_run + 1;
      if (obs !== exp) begin
         tests_failed = tests_failed + 1;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      wr_cnt   = 0;
      byte_cnt = 0;
   endtask

   task automatic pulse_start(input logic [ADDR_W:0] l);
      bus.start = 1'b1;
      bus.len   = l;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit ok;
      ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (bus.in_ready) ok = 1'b1;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      if (!ok) check_eq("byte_timeout", 32'd0, 32'd1);
      repeat (gap) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_done(input string tag, input int max_cycles);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < max_cycles && !seen; i++) begin
         @(negedge clk);
         if (bus.done) seen = 1'b1;
         @(posedge clk); #1;
      end
      check_eq(tag, 32'(seen), 32'd1);
   endtask

   task automatic check_status(input string tag, input logic exp_err);
      check_eq({tag, "_done"}, 32'(bus.done), 32'd1);
      check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check_eq({tag, "_hold"}, 32'(bus.core_hold), 32'd0);
      check_eq({tag, "_err"},  32'(bus.err), 32'(exp_err));
   endtask

   // 8-byte two-word load used by the first two tests
   task automatic run_two_words(input string tag, input int gap);
      logic [7:0] bytes [0:7];
      bytes = '{8'h0c, 8'h00, 8'h80, 8'h03, 8'h0d, 8'h04, 8'h80, 8'h03};
      clear_mon();
      pulse_start(5'd2);
      @(negedge clk);
      check_eq({tag, "_busy_up"}, 32'(bus.busy), 32'd1);
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) send_byte(bytes[i], gap);
`ifdef LOADER_CSUM_EN
      send_byte(8'h23, gap);  // 8-bit sum of the eight data bytes
`endif
      wait_done({tag, "_done_wait"}, 20);
      check_eq({tag, "_nwr"},   32'(wr_cnt), 32'd2);
      check_eq({tag, "_addr0"}, wr_addr[0], 32'd0);
      check_eq({tag, "_data0"}, wr_data[0], 32'h0380000c);
      check_eq({tag, "_addr1"}, wr_addr[1], 32'd1);
      check_eq({tag, "_data1"}, wr_data[1], 32'h0380040d);
`ifdef LOADER_CSUM_EN
      check_eq({tag, "_nbytes"}, 32'(byte_cnt), 32'd9);
`else
      check_eq({tag, "_nbytes"}, 32'(byte_cnt), 32'd8);
`endif
      check_status(tag, 1'b0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.start    = 1'b0;
      bus.len      = '0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;

      // ---- reset state ----
      repeat (2) @(negedge clk);
      check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check_eq("rst_we",       32'(bus.we), 32'd0);
      check_eq("rst_waddr",    32'(bus.waddr), 32'd0);
      check_eq("rst_wdata",    bus.wdata, 32'd0);
      check_eq("rst_busy",     32'(bus.busy), 32'd0);
      check_eq("rst_hold",     32'(bus.core_hold), 32'd0);
      check_eq("rst_done",     32'(bus.done), 32'd0);
      check_eq("rst_err",      32'(bus.err), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // ---- two words, back-to-back bytes, then with in_valid gaps ----
      run_two_words("t1", 0);
      run_two_words("t2", 1);

      // ---- len = 0: straight to DONE, nothing accepted ----
      clear_mon();
      pulse_start(5'd0);
      wait_done("t3_done_wait", 3);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h5a;
      repeat (3) begin
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      check_eq("t3_nwr",    32'(wr_cnt), 32'd0);
      check_eq("t3_nbytes", 32'(byte_cnt), 32'd0);
      check_eq("t3_done",   32'(bus.done), 32'd1);

`ifdef LOADER_CSUM_EN
      // ---- checksum mismatch ----
      clear_mon();
      pulse_start(5'd1);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_byte(8'h33, 0);
      send_byte(8'h44, 0);
      send_byte(8'h00, 0);  // expected sum is 0xaa
      wait_done("t4_done_wait", 10);
      check_eq("t4_nwr",  32'(wr_cnt), 32'd1);
      check_eq("t4_data", wr_data[0], 32'h44332211);
      check_status("t4", 1'b1);
`endif

      // ---- start pulse during RECV is ignored ----
      clear_mon();
      pulse_start(5'd3);
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      pulse_start(5'd1);
      for (int i = 3; i <= 12; i++) send_byte(8'(i), 0);
`ifdef LOADER_CSUM_EN
      send_byte(8'h4e, 0);  // 1+2+...+12 = 78
`endif
      wait_done("t5_done_wait", 20);
      check_eq("t5_nwr",   32'(wr_cnt), 32'd3);
      check_eq("t5_addr2", wr_addr[2], 32'd2);
      check_eq("t5_data0", wr_data[0], 32'h04030201);
      check_eq("t5_data1", wr_data[1], 32'h08070605);
      check_eq("t5_data2", wr_data[2], 32'h0c0b0a09);
      check_status("t5", 1'b0);

      // ---- len above depth is clamped to 16 words, addresses 0..15 ----
      clear_mon();
      pulse_start(5'd31);
      for (int i = 0; i < 64; i++) send_byte(8'(i), 0);
`ifdef LOADER_CSUM_EN
      send_byte(8'he0, 0);  // 0+1+...+63 = 2016 mod 256
`endif
      wait_done("t6_done_wait", 20);
      check_eq("t6_nwr",    32'(wr_cnt), 32'd16);
      check_eq("t6_addr15", wr_addr[15], 32'd15);
      check_eq("t6_data0",  wr_data[0], 32'h03020100);
      check_eq("t6_data15", wr_data[15], 32'h3f3e3d3c);
      check_status("t6", 1'b0);

      // ---- reset in the middle of the second word ----
      clear_mon();
      pulse_start(5'd2);
      for (int i = 0; i < 6; i++) send_byte(8'h70 + 8'(i), 0);
      rst_n = 1'b0;
      #1;
      check_eq("t7_rst_busy",     32'(bus.busy), 32'd0);
      check_eq("t7_rst_in_ready", 32'(bus.in_ready), 32'd0);
      check_eq("t7_rst_waddr",    32'(bus.waddr), 32'd0);
      check_eq("t7_rst_wdata",    bus.wdata, 32'd0);
      check_eq("t7_rst_we",       32'(bus.we), 32'd0);
      check_eq("t7_nwr_before",   32'(wr_cnt), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      clear_mon();
      pulse_start(5'd1);
      send_byte(8'haa, 0);
      send_byte(8'hbb, 0);
      send_byte(8'hcc, 0);
      send_byte(8'hdd, 0);
`ifdef LOADER_CSUM_EN
      send_byte(8'h0e, 0);  // aa+bb+cc+dd = 0x30e
`endif
      wait_done("t7_done_wait", 10);
      check_eq("t7_nwr",  32'(wr_cnt), 32'd1);
      check_eq("t7_addr", wr_addr[0], 32'd0);
      check_eq("t7_data", wr_data[0], 32'hddccbbaa);
      check_status("t7", 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
